// File: rtl/asip_mem_pkg.sv
// Shared memory-map constants and entry types for the ASIP image capture/load paths.
package asip_mem_pkg;

  localparam logic [31:0] OUT_IMG_BASE = 32'd262144;
  localparam logic [31:0] OUT_IMG_SIZE = 32'd65536;
  localparam int          OFS_W        = 16;

  typedef struct packed {
    logic [OFS_W-1:0] ofs;
    logic [7:0]       pix;
  } pix_entry_t;

  // Unsigned window test; the subtraction keeps the upper bound safe near 2**32.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [31:0] rel;
    rel = addr - base;
    return (addr >= base) && (rel < size);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head_data is valid whenever !empty; a push is taken
// one cycle to visibility; when full, a push is accepted only alongside a pop.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_MAX);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Storage is cleared on reset so the head outputs read as zero while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/img_out_capture.sv
// Snoops CPU stores into the output-image window and streams them as offset/pixel.
// One-cycle store-to-valid latency; stores arriving with the FIFO full and no pop are dropped.
module img_out_capture
  import asip_mem_pkg::*;
#(
  parameter logic [31:0] OUT_BASE = OUT_IMG_BASE,
  parameter logic [31:0] OUT_SIZE = OUT_IMG_SIZE,
  parameter int          DEPTH    = 16,
  parameter int          OFS_W    = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [31:0]              data_mem_address_i,
  input  logic [31:0]              data_mem_in_data_i,
  input  logic                     data_mem_WE_i,
  output logic                     pix_valid_o,
  input  logic                     pix_ready_i,
  output logic [OFS_W-1:0]         pix_offset_o,
  output logic [7:0]               pix_data_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     almost_full_o,
  output logic                     overflow_o,
  output logic [31:0]              pix_count_o,
  output logic                     done_o
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int EW  = $bits(pix_entry_t);
  localparam int EOW = EW - 8;
  localparam logic [CW-1:0] AF_LEVEL = DEPTH - 2;

  logic [31:0] rel_addr;
  logic        in_region;
  logic        pop_fire;
  logic        push_ok;
  logic        fifo_full;
  logic        fifo_empty;
  pix_entry_t  wr_entry;
  pix_entry_t  rd_entry;
  logic        unused_bits;

  assign rel_addr  = data_mem_address_i - OUT_BASE;
  assign in_region = data_mem_WE_i && in_window(data_mem_address_i, OUT_BASE, OUT_SIZE);
  assign pop_fire  = pix_valid_o && pix_ready_i;
  assign push_ok   = in_region && (!fifo_full || pop_fire);

  always_comb begin
    wr_entry     = '0;
    wr_entry.ofs = rel_addr[EOW-1:0];
    wr_entry.pix = data_mem_in_data_i[7:0];
  end

  assign unused_bits = ^{data_mem_in_data_i[31:8], rel_addr[31:EOW]};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (in_region),
    .push_data (wr_entry),
    .pop       (pix_ready_i),
    .head_data (rd_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_o)
  );

  assign pix_valid_o   = !fifo_empty;
  assign pix_offset_o  = OFS_W'(rd_entry.ofs);
  assign pix_data_o    = rd_entry.pix;
  assign almost_full_o = (fifo_count_o >= AF_LEVEL);

  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_o <= 1'b0;
    end else if (in_region && !push_ok) begin
      overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pix_count_o <= '0;
    end else if (push_ok && (pix_count_o != 32'hFFFF_FFFF)) begin
      pix_count_o <= pix_count_o + 32'd1;
    end
  end

  // Overshooting OUT_SIZE means the CPU rewrote pixels; done then stays low.
  assign done_o = (pix_count_o == OUT_SIZE) && fifo_empty;

endmodule
